bulk_in_retry_endp: RTL and testbench
=====================================

# bulk_in_retry_endp

Parametrised IN bulk endpoint for USB_CDC. It succeeds the fixed-size IN FIFO path: a configurable-depth byte buffer that frees bytes only when the host ACKs them, so an unacknowledged packet is replayed byte-for-byte. It also adds zero-length-packet (ZLP) termination and a short-packet hold timer. It sits between the application byte stream and the SIE IN interface.

## Interface
- IN_MAXPACKETSIZE, 64: max packet bytes; one of 8/16/32/64.
- FIFO_DEPTH, 128: buffer bytes; power of 2, ≥ 2*IN_MAXPACKETSIZE.
- ZLP_EN, 1: 1 = send a ZLP after a full-size packet that drains the buffer.
- HOLD_TICKS, 0: clk_gate_i ticks of app idle before a short packet may be sent; 0 = send immediately.
- clk_i  in  1  single clock, 12MHz*BIT_SAMPLES; all logic on posedge.
- rstn_i  in  1  synchronous, active-low reset.
- clk_gate_i  in  1  one-cycle enable every BIT_SAMPLES cycles; qualifies every SIE-side input/output update.
- bus_reset_i  in  1  USB bus reset; same effect as rstn_i low, sampled on clk_gate_i.
- app_in_data_i  in  8  application byte.
- app_in_valid_i  in  1  byte valid.
- app_in_ready_o  out  1  buffer not full; write when valid&ready on any clk_i edge (not gated).
- in_data_o  out  8  byte to SIE; valid while in_valid_o high.
- in_valid_o  out  1  current packet has bytes left.
- in_zlp_o  out  1  current packet is zero-length; SIE sends a DATA packet with no payload.
- in_req_i  in  1  with in_ready_i: new IN token, start a packet.
- in_ready_i  in  1  SIE strobe, high for one gated period.
- in_data_ack_i  in  1  with in_ready_i: host ACKed the last packet.
- in_level_o  out  $clog2(FIFO_DEPTH)+1  bytes held (unacked, including in-flight).

## Operation
- Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH:
  - wr_ptr: app write pointer.
  - ack_ptr: oldest unacked byte.
  - rd_ptr: SIE read pointer.
- Derived values: level = wr_ptr − ack_ptr; full = (level == FIFO_DEPTH); app_in_ready_o = ~full.
- Registered state:
  - pkt_len: $clog2(IN_MAXPACKETSIZE)+1 bits.
  - left: bytes remaining in the packet.
  - pend: last packet not yet ACKed.
  - zlp_due: set when an ACKed packet had pkt_len == IN_MAXPACKETSIZE and left level == 0, with ZLP_EN = 1; cleared by any later packet being ACKed.
  - hold counter: reloaded to HOLD_TICKS on each app write; decrements per clk_gate_i down to 0.
- FSM states: IDLE, SEND, WAIT_ACK.
- Packet start (clk_gate_i & in_req_i & in_ready_i, accepted in any state): rd_ptr ← ack_ptr, then the first matching rule applies:
  - pend: resend with the same pkt_len (0 = ZLP).
  - level ≥ MPS: pkt_len = MPS.
  - level > 0 and hold = 0: pkt_len = level.
  - zlp_due: pkt_len = 0.
  - otherwise NAK: stay in / go to IDLE with in_valid_o = in_zlp_o = 0; pend unchanged.
- For any non-NAK start: left ← pkt_len, pend ← 1, go to SEND.
- SEND:
  - in_valid_o = (left ≠ 0); in_zlp_o = (pkt_len == 0).
  - On clk_gate_i & in_ready_i & in_valid_o: rd_ptr++, left−−.
  - When left = 0 and in_zlp_o has been presented for one in_ready_i period, go to WAIT_ACK.
- WAIT_ACK: on clk_gate_i & in_ready_i & in_data_ack_i: ack_ptr += pkt_len, pend ← 0, update zlp_due, go to IDLE.
- Ack and in_req in the same gated cycle: apply the ack first, then evaluate the start rules on the updated state.
- A new in_req without an ack triggers a retry: the same bytes are replayed from ack_ptr.
- An app write in the same cycle as an ack updates both pointers; level reflects both.

## Timing
- Reset: rstn_i low at a clk_i edge, or bus_reset_i high at a gated edge, clears everything in that cycle:
  - Pointers, pend, zlp_due and hold → 0; FSM → IDLE.
  - in_valid_o = 0, in_zlp_o = 0, in_level_o = 0, in_data_o = 0.
  - app_in_ready_o = 0 while rstn_i is low; 1 from the first cycle after release.
- Reset mid-packet discards all data, including unacked bytes.
- App write → in_level_o +1 on the next clk_i edge. The byte is eligible at the next packet start.
- in_valid_o / in_zlp_o / left / rd_ptr change only on clk_gate_i edges.
- in_data_o = mem[rd_ptr] is valid one clk_i cycle after rd_ptr changes, i.e. well before the next gate.
- Full: app_in_ready_o drops on the edge where level reaches FIFO_DEPTH. It rises on the edge after the ack that frees space.

## Test plan
- MPS=8, write 20 bytes, three IN+ACK → packets of 8, 8, 4 bytes; bytes 0..19 in order; in_level_o ends 0.
- Write 8 bytes, IN, no ACK, IN again → identical 8 bytes replayed; in_level_o stays 8 until the ACK.
- ZLP_EN=1, write exactly 8, IN+ACK, IN → in_zlp_o=1, in_valid_o=0; after its ACK the next IN is a NAK.
- HOLD_TICKS=4, write 3 bytes, IN 2 ticks later → NAK; IN after ≥4 ticks → 3-byte packet.
- FIFO_DEPTH=16: write 16 → app_in_ready_o=0; the write of byte 17 is refused. IN 8+ACK → ready=1 the next cycle; 8 more bytes accepted. Check pointer wrap integrity.
- rstn_i low in the middle of SEND → in_valid_o=0, in_level_o=0; the next IN is a NAK.

Source files
------------

// File: rtl/bulk_in_retry_endp.sv
// IN bulk endpoint: byte buffer released only on host ACK so an unacknowledged
// packet is replayed, with zero-length-packet termination and a short-packet hold timer.
module bulk_in_retry_endp #(
   parameter int unsigned IN_MAXPACKETSIZE = 64,
   parameter int unsigned FIFO_DEPTH       = 128,
   parameter bit          ZLP_EN           = 1'b1,
   parameter int unsigned HOLD_TICKS       = 0
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          clk_gate_i,
   input  logic                          bus_reset_i,
   input  logic [7:0]                    app_in_data_i,
   input  logic                          app_in_valid_i,
   output logic                          app_in_ready_o,
   output logic [7:0]                    in_data_o,
   output logic                          in_valid_o,
   output logic                          in_zlp_o,
   input  logic                          in_req_i,
   input  logic                          in_ready_i,
   input  logic                          in_data_ack_i,
   output logic [$clog2(FIFO_DEPTH):0]   in_level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = $clog2(IN_MAXPACKETSIZE) + 1;
   localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]   MPS_LVL_C = (AW + 1)'(IN_MAXPACKETSIZE);
   localparam logic [AW:0]   PTR_ONE_C = (AW + 1)'(1);
   localparam logic [PW-1:0] MPS_C     = PW'(IN_MAXPACKETSIZE);
   localparam logic [PW-1:0] LEN_ONE_C = PW'(1);
   localparam logic [HW-1:0] HOLD_C    = HW'(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_ONE_C = HW'(1);

   // state    | meaning
   // IDLE     | no packet in flight; next IN token either starts a packet or is NAKed
   // SEND     | packet bytes (or a ZLP) are being presented to the SIE
   // WAIT_ACK | packet fully presented; waiting for the host ACK
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    ack_ptr_q, ack_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]  pkt_len_q, pkt_len_d;
   logic [PW-1:0]  left_q, left_d;
   logic           pend_q, pend_d;
   logic           zlp_due_q, zlp_due_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic           in_valid_q, in_valid_d;
   logic           in_zlp_q, in_zlp_d;
   logic [7:0]     in_data_q;
   logic           rdy_en_q;
   logic [7:0]     mem_q [FIFO_DEPTH];

   logic [AW:0]    level;
   logic           full;
   logic           wr_fire;
   logic           gated_rst;
   logic           ready_tick;
   logic           ack_fire;
   logic           start_fire;

   logic [AW:0]    ack_eff;
   logic [AW:0]    lvl_eff;
   logic           pend_eff;
   logic           zlp_eff;
   logic [PW-1:0]  len_sel;
   logic           go;

   assign level          = wr_ptr_q - ack_ptr_q;
   assign full           = (level == DEPTH_C);
   assign app_in_ready_o = rstn_i & rdy_en_q & ~full;
   assign wr_fire        = app_in_valid_i & app_in_ready_o;
   assign gated_rst      = clk_gate_i & bus_reset_i;
   assign ready_tick     = clk_gate_i & in_ready_i;
   assign ack_fire       = ready_tick & in_data_ack_i & (state_q == ST_WAIT_ACK);
   assign start_fire     = ready_tick & in_req_i;

   assign in_level_o = level;
   assign in_data_o  = in_data_q;
   assign in_valid_o = in_valid_q;
   assign in_zlp_o   = in_zlp_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      ack_ptr_d = ack_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      pkt_len_d = pkt_len_q;
      left_d    = left_q;
      pend_d    = pend_q;
      zlp_due_d = zlp_due_q;
      hold_d    = hold_q;
      state_d   = state_q;
      ack_eff   = ack_ptr_q;
      pend_eff  = pend_q;
      zlp_eff   = zlp_due_q;
      len_sel   = pkt_len_q;
      go        = 1'b0;

      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end

      if (wr_fire) begin
         hold_d = HOLD_C;
      end else if (clk_gate_i && (hold_q != '0)) begin
         hold_d = hold_q - HOLD_ONE_C;
      end

      // The ACK is retired first so a same-cycle IN token sees the freed buffer.
      if (ack_fire) begin
         ack_eff  = ack_ptr_q + (AW + 1)'(pkt_len_q);
         pend_eff = 1'b0;
         zlp_eff  = ZLP_EN && (pkt_len_q == MPS_C) && (wr_ptr_q == ack_eff);
         state_d  = ST_IDLE;
      end
      ack_ptr_d = ack_eff;
      pend_d    = pend_eff;
      zlp_due_d = zlp_eff;
      lvl_eff   = wr_ptr_q - ack_eff;

      if (start_fire) begin
         rd_ptr_d = ack_eff;
         go       = 1'b1;
         if (pend_eff) begin
            len_sel = pkt_len_q;
         end else if (lvl_eff >= MPS_LVL_C) begin
            len_sel = MPS_C;
         end else if ((lvl_eff != '0) && (hold_q == '0)) begin
            len_sel = lvl_eff[PW-1:0];
         end else if (zlp_eff) begin
            len_sel = '0;
         end else begin
            go = 1'b0;
         end

         if (go) begin
            pkt_len_d = len_sel;
            left_d    = len_sel;
            pend_d    = 1'b1;
            state_d   = ST_SEND;
         end else begin
            state_d   = ST_IDLE;
         end
      end else if ((state_q == ST_SEND) && ready_tick) begin
         if (left_q != '0) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE_C;
            left_d   = left_q - LEN_ONE_C;
         end
         if (left_q <= LEN_ONE_C) begin
            state_d = ST_WAIT_ACK;
         end
      end

      in_valid_d = (state_d == ST_SEND) && (left_d != '0);
      in_zlp_d   = (state_d == ST_SEND) && (pkt_len_d == '0);
   end

   always_ff @(posedge clk_i) begin
      rdy_en_q <= rstn_i;
      if (!rstn_i || gated_rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         ack_ptr_q  <= '0;
         rd_ptr_q   <= '0;
         pkt_len_q  <= '0;
         left_q     <= '0;
         pend_q     <= 1'b0;
         zlp_due_q  <= 1'b0;
         hold_q     <= '0;
         in_valid_q <= 1'b0;
         in_zlp_q   <= 1'b0;
         in_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         ack_ptr_q  <= ack_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pkt_len_q  <= pkt_len_d;
         left_q     <= left_d;
         pend_q     <= pend_d;
         zlp_due_q  <= zlp_due_d;
         hold_q     <= hold_d;
         in_valid_q <= in_valid_d;
         in_zlp_q   <= in_zlp_d;
         in_data_q  <= mem_q[rd_ptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_fire) begin
         mem_q[wr_ptr_q[AW-1:0]] <= app_in_data_i;
      end
   end

endmodule

// File: tb/tb_bulk_in_retry_endp.sv
// Bench for bulk_in_retry_endp: random byte streams and IN/ACK sequences checked
// against a queue-based model of the acknowledged-release buffer.
module tb_bulk_in_retry_endp;

   localparam int MPS   = 8;
   localparam int DEPTH = 16;
   localparam int HOLD  = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          clk_gate_i = 1'b0;
   logic          bus_reset_i = 1'b0;
   logic [7:0]    app_in_data_i = '0;
   logic          app_in_valid_i = 1'b0;
   logic          app_in_ready_o;
   logic [7:0]    in_data_o;
   logic          in_valid_o;
   logic          in_zlp_o;
   logic          in_req_i = 1'b0;
   logic          in_ready_i = 1'b0;
   logic          in_data_ack_i = 1'b0;
   logic [LW-1:0] in_level_o;

   bulk_in_retry_endp #(
      .IN_MAXPACKETSIZE(MPS),
      .FIFO_DEPTH(DEPTH),
      .ZLP_EN(1'b1),
      .HOLD_TICKS(HOLD)
   ) dut (
      .clk_i(clk_i),
      .rstn_i(rstn_i),
      .clk_gate_i(clk_gate_i),
      .bus_reset_i(bus_reset_i),
      .app_in_data_i(app_in_data_i),
      .app_in_valid_i(app_in_valid_i),
      .app_in_ready_o(app_in_ready_o),
      .in_data_o(in_data_o),
      .in_valid_o(in_valid_o),
      .in_zlp_o(in_zlp_o),
      .in_req_i(in_req_i),
      .in_ready_i(in_ready_i),
      .in_data_ack_i(in_data_ack_i),
      .in_level_o(in_level_o)
   );

   // reference model: bytes held (unacked) in order, plus packet bookkeeping
   logic [7:0] mq[$];
   bit         pend_m;
   int         pkt_len_m;
   bit         zlp_due_m;
   bit         awaiting_m;
   int         idle_gates = 1000;
   bit         exp_ready = 1'b0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         gcnt = 0;

   initial forever #5 clk_i = ~clk_i;

   initial forever begin
      @(negedge clk_i);
      gcnt = (gcnt + 1) % 4;
      clk_gate_i = (gcnt == 0);
   end

   // gated ticks elapsed since the last accepted application write
   initial forever begin
      @(posedge clk_i);
      if (app_in_valid_i && exp_ready) idle_gates = 0;
      else if (clk_gate_i) idle_gates++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      mq.delete();
      pend_m = 0; pkt_len_m = 0; zlp_due_m = 0; awaiting_m = 0;
      idle_gates = 1000;
   endtask

   task automatic model_ack();
      repeat (pkt_len_m) void'(mq.pop_front());
      zlp_due_m  = (pkt_len_m == MPS) && (mq.size() == 0);
      pend_m     = 0;
      awaiting_m = 0;
   endtask

   task automatic align_gate();
      @(negedge clk_i); #1;
      for (int i = 0; i < 8 && !clk_gate_i; i++) begin
         @(negedge clk_i); #1;
      end
   endtask

   task automatic write_byte(input logic [7:0] b);
      @(negedge clk_i);
      exp_ready = (mq.size() < DEPTH);
      app_in_data_i = b; app_in_valid_i = 1'b1;
      #1;
      n_checks++;
      if (app_in_ready_o !== exp_ready) begin
         n_fail++; $display("FAIL app_ready: got %b expected %b", app_in_ready_o, exp_ready);
      end
      @(posedge clk_i);
      if (exp_ready) mq.push_back(b);
      #1;
      app_in_valid_i = 1'b0; exp_ready = 1'b0;
      n_checks++;
      if (in_level_o !== LW'(mq.size())) begin
         n_fail++; $display("FAIL level_after_write: got %0d expected %0d", in_level_o, mq.size());
      end
   endtask

   task automatic write_rand(input int n);
      for (int i = 0; i < n; i++) write_byte(8'($urandom));
   endtask

   task automatic do_in(input bit with_ack, input string tag);
      int exp_len;
      align_gate();
      if (with_ack && awaiting_m) model_ack();
      if (pend_m) exp_len = pkt_len_m;
      else if (mq.size() >= MPS) exp_len = MPS;
      else if (mq.size() > 0 && idle_gates >= HOLD) exp_len = mq.size();
      else if (zlp_due_m) exp_len = 0;
      else exp_len = -1;
      if (exp_len >= 0) begin
         pend_m = 1; pkt_len_m = exp_len; awaiting_m = 0;
      end
      in_req_i = 1'b1; in_ready_i = 1'b1; in_data_ack_i = with_ack;
      @(posedge clk_i); #1;
      in_req_i = 1'b0; in_ready_i = 1'b0; in_data_ack_i = 1'b0;
      n_checks++;
      if (in_valid_o !== (exp_len > 0)) begin
         n_fail++; $display("FAIL %s start valid: got %b expected %b", tag, in_valid_o, exp_len > 0);
      end
      n_checks++;
      if (in_zlp_o !== (exp_len == 0)) begin
         n_fail++; $display("FAIL %s start zlp: got %b expected %b", tag, in_zlp_o, exp_len == 0);
      end
      n_checks++;
      if (in_level_o !== LW'(mq.size())) begin
         n_fail++; $display("FAIL %s start level: got %0d expected %0d", tag, in_level_o, mq.size());
      end
      for (int i = 0; i < exp_len; i++) begin
         align_gate();
         n_checks++;
         if (in_valid_o !== 1'b1 || in_data_o !== mq[i]) begin
            n_fail++;
            $display("FAIL %s byte %0d: got valid=%b data=%02h expected valid=1 data=%02h",
                     tag, i, in_valid_o, in_data_o, mq[i]);
         end
         in_ready_i = 1'b1;
         @(posedge clk_i); #1;
         in_ready_i = 1'b0;
      end
      if (exp_len == 0) begin
         align_gate();
         in_ready_i = 1'b1;
         @(posedge clk_i); #1;
         in_ready_i = 1'b0;
      end
      if (exp_len >= 0) begin
         awaiting_m = 1;
         n_checks++;
         if (in_valid_o !== 1'b0 || in_zlp_o !== 1'b0) begin
            n_fail++; $display("FAIL %s end: got valid=%b zlp=%b expected 0 0", tag, in_valid_o, in_zlp_o);
         end
      end
   endtask

   task automatic ack_only(input string tag);
      align_gate();
      if (awaiting_m) model_ack();
      in_ready_i = 1'b1; in_data_ack_i = 1'b1;
      @(posedge clk_i); #1;
      in_ready_i = 1'b0; in_data_ack_i = 1'b0;
      n_checks++;
      if (in_level_o !== LW'(mq.size())) begin
         n_fail++; $display("FAIL %s ack level: got %0d expected %0d", tag, in_level_o, mq.size());
      end
      n_checks++;
      if (app_in_ready_o !== (mq.size() < DEPTH)) begin
         n_fail++; $display("FAIL %s ack ready: got %b expected %b", tag, app_in_ready_o, mq.size() < DEPTH);
      end
   endtask

   task automatic do_rstn(input string tag);
      @(negedge clk_i);
      rstn_i = 1'b0; exp_ready = 1'b0;
      #1;
      n_checks++;
      if (app_in_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL %s ready in reset: got %b expected 0", tag, app_in_ready_o);
      end
      repeat (2) @(posedge clk_i);
      #1;
      n_checks++;
      if (in_valid_o !== 1'b0 || in_zlp_o !== 1'b0 || in_level_o !== '0 || in_data_o !== 8'h00) begin
         n_fail++;
         $display("FAIL %s reset outputs: got valid=%b zlp=%b level=%0d data=%02h expected 0 0 0 00",
                  tag, in_valid_o, in_zlp_o, in_level_o, in_data_o);
      end
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(posedge clk_i); #1;
      model_reset();
      n_checks++;
      if (app_in_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL %s ready after release: got %b expected 1", tag, app_in_ready_o);
      end
   endtask

   task automatic test_reset();
      do_rstn("reset");
   endtask

   task automatic test_packets();
      write_rand(16);
      do_in(0, "pkt1");
      ack_only("pkt1");
      write_rand(4);
      do_in(0, "pkt2");
      repeat (5) align_gate();
      do_in(1, "pkt3_ack_and_start");
      ack_only("pkt3");
      n_checks++;
      if (in_level_o !== '0) begin
         n_fail++; $display("FAIL packets drained level: got %0d expected 0", in_level_o);
      end
   endtask

   task automatic test_full();
      write_rand(16);
      n_checks++;
      if (app_in_ready_o !== 1'b0) begin
         n_fail++; $display("FAIL full ready: got %b expected 0", app_in_ready_o);
      end
      write_byte(8'hA5);
      do_in(0, "full_pkt1");
      ack_only("full_pkt1");
      write_rand(8);
      do_in(0, "wrap_pkt2");
      do_in(1, "wrap_pkt3");
      ack_only("wrap_pkt3");
   endtask

   task automatic test_retry();
      write_rand(8);
      do_in(0, "retry_first");
      do_in(0, "retry_replay");
      do_in(0, "retry_replay2");
      ack_only("retry");
   endtask

   task automatic test_zlp();
      do_in(0, "zlp");
      ack_only("zlp");
      do_in(0, "after_zlp_nak");
   endtask

   task automatic test_hold();
      write_rand(3);
      align_gate();
      do_in(0, "hold_early_nak");
      repeat (5) align_gate();
      do_in(0, "hold_expired");
      ack_only("hold");
   endtask

   task automatic test_reset_mid_send();
      write_rand(10);
      align_gate();
      in_req_i = 1'b1; in_ready_i = 1'b1;
      @(posedge clk_i); #1;
      in_req_i = 1'b0; in_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         align_gate();
         n_checks++;
         if (in_valid_o !== 1'b1 || in_data_o !== mq[i]) begin
            n_fail++;
            $display("FAIL mid_send byte %0d: got valid=%b data=%02h expected valid=1 data=%02h",
                     i, in_valid_o, in_data_o, mq[i]);
         end
         in_ready_i = 1'b1;
         @(posedge clk_i); #1;
         in_ready_i = 1'b0;
      end
      do_rstn("mid_send");
      do_in(0, "after_rstn_nak");
   endtask

   task automatic test_bus_reset();
      write_rand(5);
      align_gate();
      bus_reset_i = 1'b1;
      @(posedge clk_i); #1;
      bus_reset_i = 1'b0;
      model_reset();
      n_checks++;
      if (in_level_o !== '0 || app_in_ready_o !== 1'b1) begin
         n_fail++; $display("FAIL bus_reset: got level=%0d ready=%b expected 0 1", in_level_o, app_in_ready_o);
      end
      do_in(0, "after_bus_reset_nak");
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 3))
            0: write_rand($urandom_range(1, 6));
            1: do_in(1'($urandom_range(0, 1)), "rand_in");
            2: ack_only("rand_ack");
            default: repeat ($urandom_range(1, 24)) @(posedge clk_i);
         endcase
      end
      do_in(1, "rand_final");
      ack_only("rand_final");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_packets();
      test_full();
      test_retry();
      test_zlp();
      test_hold();
      test_reset_mid_send();
      test_bus_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
